// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage feeding the decoder.
//
// Holds the fetch PC, issues single-outstanding word reads over a req/ack
// bus and buffers returned words in a small circular FIFO. The head entry is
// offered to decode with a valid/ready handshake. A redirect flushes the
// buffer and restarts fetch at the target; a request already on the bus is
// never aborted, its data is simply discarded when it returns.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : a redirect target with [1:0] != 0 parks the unit in FAULT
//               (O_fault = 1, no fetches) until an aligned redirect.
//   undefined : redirect target bits [1:0] are ignored, O_fault is tied 0.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  instruction buffer entries, power of two, 2..8
//
// Ports:
//   I_clk, I_rst_n        clock, asynchronous active-low reset
//   I_redirect(_pc)       flush and restart fetch at the target
//   I_ready               decode accepts the head entry
//   O_valid/O_instr/O_pc  head entry handshake and contents
//   O_bus_req/O_bus_addr  instruction memory read request
//   I_bus_ack/I_bus_data  read completion and returned word
//   O_fault               misaligned fetch target
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_redirect,
  input  logic [31:0] I_redirect_pc,
  input  logic        I_ready,
  output logic        O_valid,
  output logic [31:0] O_instr,
  output logic [31:0] O_pc,
  output logic        O_bus_req,
  output logic [31:0] O_bus_addr,
  input  logic        I_bus_ack,
  input  logic [31:0] I_bus_data,
  output logic        O_fault
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, REQ, DISCARD, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
`endif

  state_t      state;
  logic [31:0] fetch_pc;
  logic        bus_req;
  logic [31:0] bus_addr;

  logic [31:0] mem_instr [FIFO_DEPTH];
  logic [31:0] mem_pc    [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;

  logic        push, pop, can_issue;
  logic [31:0] pc_inc, target, discard_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault, fault_pend, tgt_bad, discard_bad;
`else
  logic unused_redirect_lo;
`endif

  always_comb begin
    pop        = (count != '0) & I_ready & ~I_redirect;
    push       = (state == REQ) & I_bus_ack & ~I_redirect;
    count_next = I_redirect ? '0 : (count + CW'(push) - CW'(pop));
    // Issuing means one outstanding next cycle, so the slot must exist now.
    can_issue  = count_next < CW'(FIFO_DEPTH);
    pc_inc     = fetch_pc + 32'd4;
`ifdef FETCH_MISALIGN_CHECK_EN
    target      = I_redirect_pc;
    tgt_bad     = I_redirect_pc[1:0] != 2'b00;
    discard_bad = I_redirect ? tgt_bad : fault_pend;
`else
    target      = {I_redirect_pc[31:2], 2'b00};
`endif
    discard_pc = I_redirect ? target : fetch_pc;
  end

`ifndef FETCH_MISALIGN_CHECK_EN
  assign unused_redirect_lo = |I_redirect_pc[1:0];
`endif

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      bus_req  <= 1'b0;
      bus_addr <= RESET_PC;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault      <= 1'b0;
      fault_pend <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (I_redirect) begin
            fetch_pc <= target;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault <= tgt_bad;
            if (tgt_bad) begin
              state <= FAULT;
            end else begin
              state    <= REQ;
              bus_req  <= 1'b1;
              bus_addr <= target;
            end
`else
            state    <= REQ;
            bus_req  <= 1'b1;
            bus_addr <= target;
`endif
          end else if (can_issue) begin
            state    <= REQ;
            bus_req  <= 1'b1;
            bus_addr <= fetch_pc;
          end
        end

        REQ: begin
          if (I_redirect) begin
            fetch_pc <= target;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault <= tgt_bad;
`endif
            if (!I_bus_ack) begin
              // Request cannot be withdrawn: keep it on the bus, drop its data.
              state <= DISCARD;
`ifdef FETCH_MISALIGN_CHECK_EN
              fault_pend <= tgt_bad;
`endif
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            else if (tgt_bad) begin
              state   <= FAULT;
              bus_req <= 1'b0;
            end
`endif
            else begin
              // Ack in the redirect cycle: data dropped, buffer empty, so the
              // target can be requested straight away.
              bus_addr <= target;
            end
          end else if (I_bus_ack) begin
            fetch_pc <= pc_inc;
            if (can_issue) begin
              bus_addr <= pc_inc;
            end else begin
              state   <= IDLE;
              bus_req <= 1'b0;
            end
          end
        end

        DISCARD: begin
          if (I_redirect) begin
            fetch_pc <= target;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault      <= tgt_bad;
            fault_pend <= tgt_bad;
`endif
          end
          if (I_bus_ack) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (discard_bad) begin
              state   <= FAULT;
              bus_req <= 1'b0;
            end else begin
              state    <= REQ;
              bus_addr <= discard_pc;
            end
`else
            // Buffer was flushed and nothing is pushed here, so credit exists.
            state    <= REQ;
            bus_addr <= discard_pc;
`endif
          end
        end

`ifdef FETCH_MISALIGN_CHECK_EN
        FAULT: begin
          if (I_redirect && !tgt_bad) begin
            fetch_pc <= target;
            fault    <= 1'b0;
            state    <= REQ;
            bus_req  <= 1'b1;
            bus_addr <= target;
          end
        end
`endif

        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= RESET_PC;
      end
    end else if (I_redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= I_bus_data;
        mem_pc[wr_ptr]    <= fetch_pc;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
    end
  end

  assign O_valid    = count != '0;
  assign O_instr    = mem_instr[rd_ptr];
  assign O_pc       = mem_pc[rd_ptr];
  assign O_bus_req  = bus_req;
  assign O_bus_addr = bus_addr;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign O_fault    = fault;
`else
  assign O_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (RESET_PC = 0x100, FIFO_DEPTH = 2).
// Bus model returns data = address ^ 32'hDEAD_BEEF, either zero-wait
// (ack follows req) or with a hand-driven ack.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;
  logic        valid;
  logic [31:0] instr, pc;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_data;
  logic        fault;

  logic auto_ack, man_ack;
  int   n_cmp = 0;
  int   n_err = 0;

  assign bus_ack  = auto_ack ? bus_req : man_ack;
  assign bus_data = bus_addr ^ KEY;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_redirect(redirect), .I_redirect_pc(redirect_pc),
    .I_ready(ready), .O_valid(valid), .O_instr(instr), .O_pc(pc),
    .O_bus_req(bus_req), .O_bus_addr(bus_addr), .I_bus_ack(bus_ack),
    .I_bus_data(bus_data), .O_fault(fault)
  );

  // Reset, then release on a negedge; the next negedge is cycle 1.
  task automatic apply_reset(input logic rdy, input logic aut);
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    ready = rdy; auto_ack = aut; man_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(1'b1, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", valid); end
    n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0", instr); end
    n_cmp++; if (pc !== RPC) begin n_err++; $display("FAIL rst_pc: got %h want %h", pc, RPC); end
    n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", bus_req); end
    n_cmp++; if (bus_addr !== RPC) begin n_err++; $display("FAIL rst_addr: got %h want %h", bus_addr, RPC); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b want 0", fault); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    apply_reset(1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", bus_req); end
    n_cmp++; if (bus_addr !== RPC) begin n_err++; $display("FAIL first_addr: got %h want %h", bus_addr, RPC); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL first_valid: got %b want 0", valid); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp = RPC + 32'(4 * i);
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", i, valid); end
      n_cmp++; if (pc !== exp) begin n_err++; $display("FAIL stream_pc[%0d]: got %h want %h", i, pc, exp); end
      n_cmp++; if (instr !== (exp ^ KEY)) begin n_err++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instr, exp ^ KEY); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    apply_reset(1'b0, 1'b1);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_req && bus_ack) n++;
    end
    n_cmp++; if (n !== 2) begin n_err++; $display("FAIL bp_acks: got %0d want 2", n); end
    n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL bp_req_low: got %b want 0", bus_req); end
    n_cmp++; if (pc !== RPC) begin n_err++; $display("FAIL bp_head: got %h want %h", pc, RPC); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n = 0;
    n_cmp++; if (bus_addr !== 32'h108) begin n_err++; $display("FAIL bp_refill_addr: got %h want 108", bus_addr); end
    repeat (6) begin
      if (bus_req && bus_ack) n++;
      @(negedge clk);
    end
    n_cmp++; if (n !== 1) begin n_err++; $display("FAIL bp_one_req: got %0d want 1", n); end
    n_cmp++; if (pc !== 32'h104) begin n_err++; $display("FAIL bp_head2: got %h want 104", pc); end
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL bp_valid2: got %b want 1", valid); end
  endtask

  task automatic test_redirect_late();
    apply_reset(1'b1, 1'b0);
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    n_cmp++; if (pc !== RPC) begin n_err++; $display("FAIL late_pc0: got %h want %h", pc, RPC); end
    n_cmp++; if (bus_addr !== 32'h104) begin n_err++; $display("FAIL late_addr0: got %h want 104", bus_addr); end
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL late_flush: got %b want 0", valid); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h104)
        begin n_err++; $display("FAIL late_hold[%0d]: got %b/%h want 1/104", i, bus_req, bus_addr); end
      if (i == 2) man_ack = 1'b1;
      @(negedge clk);
    end
    man_ack = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL late_dropped: got %b want 0", valid); end
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h200)
      begin n_err++; $display("FAIL late_newreq: got %b/%h want 1/200", bus_req, bus_addr); end
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    n_cmp++; if (valid !== 1'b1 || pc !== 32'h200)
      begin n_err++; $display("FAIL late_target: got %b/%h want 1/200", valid, pc); end
    n_cmp++; if (instr !== (32'h200 ^ KEY)) begin n_err++; $display("FAIL late_instr: got %h want %h", instr, 32'h200 ^ KEY); end
  endtask

  task automatic test_redirect_ack();
    apply_reset(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    n_cmp++; if (pc !== 32'h104 || bus_addr !== 32'h108)
      begin n_err++; $display("FAIL ra_pre: got %h/%h want 104/108", pc, bus_addr); end
    redirect = 1'b1; redirect_pc = 32'h400;
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ra_empty: got %b want 0", valid); end
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h400)
      begin n_err++; $display("FAIL ra_req: got %b/%h want 1/400", bus_req, bus_addr); end
    @(negedge clk);
    n_cmp++; if (valid !== 1'b1 || pc !== 32'h400)
      begin n_err++; $display("FAIL ra_pc0: got %b/%h want 1/400", valid, pc); end
    @(negedge clk);
    n_cmp++; if (pc !== 32'h404) begin n_err++; $display("FAIL ra_pc1: got %h want 404", pc); end
  endtask

  task automatic test_wrap();
    apply_reset(1'b1, 1'b1);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++; if (bus_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h want fffffffc", bus_addr); end
    @(negedge clk);
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc0: got %h want fffffffc", pc); end
    @(negedge clk);
    n_cmp++; if (valid !== 1'b1 || pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc1: got %b/%h want 1/0", valid, pc); end
    @(negedge clk);
    n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL wrap_pc2: got %h want 4", pc); end
  endtask

  task automatic test_misalign();
    apply_reset(1'b1, 1'b1);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h202;
    @(negedge clk);
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL mis_fault: got %b want 1", fault); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus_req !== 1'b0 || valid !== 1'b0)
        begin n_err++; $display("FAIL mis_idle[%0d]: got %b/%b want 0/0", i, bus_req, valid); end
      @(negedge clk);
    end
    redirect = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL mis_clear: got %b want 0", fault); end
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h300)
      begin n_err++; $display("FAIL mis_req: got %b/%h want 1/300", bus_req, bus_addr); end
    @(negedge clk);
    n_cmp++; if (valid !== 1'b1 || pc !== 32'h300)
      begin n_err++; $display("FAIL mis_pc: got %b/%h want 1/300", valid, pc); end
`else
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL mis_fault: got %b want 0", fault); end
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h200)
      begin n_err++; $display("FAIL mis_req: got %b/%h want 1/200", bus_req, bus_addr); end
    @(negedge clk);
    n_cmp++; if (valid !== 1'b1 || pc !== 32'h200)
      begin n_err++; $display("FAIL mis_pc: got %b/%h want 1/200", valid, pc); end
    n_cmp++; if (instr !== (32'h200 ^ KEY)) begin n_err++; $display("FAIL mis_instr: got %h want %h", instr, 32'h200 ^ KEY); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_late();
    test_redirect_ack();
    test_wrap();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the decoder. It holds the fetch PC, issues single-outstanding word reads to instruction memory over a req/ack bus, and buffers returned words in a small FIFO. It presents one instruction at a time to decode with a valid/ready handshake; decode's register enable is `O_valid & I_ready`. Branch and jump redirects from execute flush the buffer and restart fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries; power of two, 2..8.

- `I_clk` input 1: clock; all state on posedge.
- `I_rst_n` input 1: reset; asynchronous, active-low.
- `I_redirect` input 1: flush and restart fetch at `I_redirect_pc`.
- `I_redirect_pc` input 32: redirect target.
- `I_ready` input 1: decode accepts the head entry this cycle.
- `O_valid` output 1: head entry valid.
- `O_instr` output 32: head instruction word, fed to decoder `I_instr`.
- `O_pc` output 32: address of `O_instr`.
- `O_bus_req` output 1: read request.
- `O_bus_addr` output 32: word address of the request.
- `I_bus_ack` input 1: read complete; `I_bus_data` valid this cycle.
- `I_bus_data` input 32: returned instruction word.
- `O_fault` output 1: misaligned fetch target (see Configuration).

## Operation
- State machine:
  - IDLE: no request outstanding.
  - REQ: `O_bus_req` is high and held stable.
  - DISCARD: request outstanding whose data is stale.
  - FAULT: misaligned target.
- Credit rule: a request issues only when `count + outstanding < FIFO_DEPTH`. A push therefore never overflows.
- IDLE goes to REQ when the credit rule allows a request. `O_bus_addr` equals `fetch_pc`.
- REQ with `I_bus_ack`:
  - Push `{fetch_pc, I_bus_data}` and advance `fetch_pc` by 4. The PC wraps modulo 2^32.
  - If credit remains, stay in REQ with the new address. Otherwise go to IDLE.
- A request cannot be aborted. `O_bus_req` and `O_bus_addr` stay constant until ack.
- `I_redirect` handling:
  - Flush the FIFO (count becomes 0) and set `fetch_pc` to the target.
  - If in REQ without ack this cycle, go to DISCARD.
  - In DISCARD, `O_bus_req` stays high with the old address. On ack, drop the data and go to IDLE/REQ for the new PC.
- Redirect in the same cycle as ack: the ack data is dropped, and no DISCARD state is entered.
- Redirect while in DISCARD: update `fetch_pc` only and remain in DISCARD.
- Redirect has priority over a simultaneous `I_ready` pop and over a push.
- Pop when `O_valid & I_ready`. Push and pop in the same cycle are both performed, and count is unchanged.
- The FIFO is a circular buffer with wrap-around read/write pointers. `O_instr`/`O_pc` are driven from the head entry.

## Timing
- Reset values:
  - `O_valid` = 0, `O_instr` = 0, `O_pc` = `RESET_PC`.
  - `O_bus_req` = 0, `O_bus_addr` = `RESET_PC`, `O_fault` = 0.
  - FIFO empty; state IDLE; `fetch_pc` = `RESET_PC`.
- First `O_bus_req` rises in the first cycle after `I_rst_n` deasserts.
- The bus may ack in the same cycle as `O_bus_req`, which is zero-wait. A word acked in cycle N appears on `O_valid` in cycle N+1.
- With a zero-wait bus and `I_ready` held high, throughput is one instruction per cycle.
- After a redirect in cycle N with no outstanding request, the request to the target is issued in cycle N+1.
- Reset asserted mid-transaction returns everything to reset values immediately. A late ack after reset release while in IDLE is ignored.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `I_redirect_pc[1:0] != 0` flushes, enters FAULT, and drives `O_fault` = 1.
  - In FAULT, no new requests are issued and `O_valid` = 0.
  - FAULT is left only by an aligned redirect. A pending DISCARD completes first.
- Not defined: `I_redirect_pc[1:0]` is ignored (forced to 0), FAULT does not exist, and `O_fault` is tied 0.

## Test plan
- Zero-wait bus, `I_ready` = 1, `RESET_PC` = 0x100 -> `O_pc` sequence is 0x100, 0x104, 0x108… on consecutive cycles starting 2 cycles after reset release.
- `I_ready` = 0, depth 2, zero-wait bus -> exactly 2 acks then `O_bus_req` = 0. Raising `I_ready` for one cycle issues exactly one new request.
- Redirect to 0x200 while 0x104 is outstanding and ack is 3 cycles late -> `O_bus_addr` stays 0x104 until ack, that data never appears, and the next `O_pc` is 0x200.
- Redirect coincident with ack and `I_ready` -> FIFO empty next cycle, acked word dropped, next request to target.
- Fetch at 0xFFFF_FFFC -> following `O_pc` is 0x0000_0000.
- With the macro, redirect to 0x202 -> `O_fault` = 1 and no `O_bus_req`. A redirect to 0x300 clears `O_fault`, and `O_pc` = 0x300 appears. Without the macro, the 0x202 redirect fetches 0x200.
